pipeline_ctrl: RTL and testbench

Central hazard controller for the 5-stage RISC-V core; the producer side of the per-stage stall vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes. It merges stall requests from IF, ID and MEM, resolves EX branch/jump redirects, and defers a redirect when it arrives while an instruction fetch is still outstanding. It also keeps saturating stall and redirect counters for performance debug.

---
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central hazard controller for the 5-stage core. It produces
//               the per-stage stall vector and merges the IF, ID and MEM stall
//               requests. It resolves EX branch/jump redirects. When a redirect
//               arrives while an instruction fetch is still outstanding, it
//               holds the redirect back until the fetch completes. It also
//               keeps saturating stall and redirect counters for debug.
// Ports       : clk            core clock, rising edge
//               rst            asynchronous reset, active-low
//               stallreq_if    IF waiting on instruction memory
//               stallreq_id    ID load-use hazard
//               stallreq_mem   MEM multi-cycle access in progress
//               branch_flag    EX resolved a taken branch/jump
//               branch_target  redirect address accompanying branch_flag
//               stall          per-stage stop bits (bit0=PC ... bit5=WB)
//               flush          kill IF/ID and ID/EX contents
//               new_pc_valid   PC loads new_pc this cycle
//               new_pc         redirect address (0 when not valid)
//               stall_cnt      cycles with stall[0]==1 (saturating)
//               redirect_cnt   redirects issued (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int CTRL_WIDTH = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallreq_if,
  input  logic                  stallreq_id,
  input  logic                  stallreq_mem,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [CTRL_WIDTH-1:0] stall,
  output logic                  flush,
  output logic                  new_pc_valid,
  output logic [ADDR_WIDTH-1:0] new_pc,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  redirect_cnt
);

  // The stop bits are contiguous from the PC upward. The first stage above
  // them keeps running and takes a bubble from its input register.
  localparam logic [CTRL_WIDTH-1:0] c_STALL_MEM = CTRL_WIDTH'(6'b011111);
  localparam logic [CTRL_WIDTH-1:0] c_STALL_ID  = CTRL_WIDTH'(6'b000111);
  localparam logic [CTRL_WIDTH-1:0] c_STALL_IF  = CTRL_WIDTH'(6'b000011);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_PEND_BR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pend_target;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_redirect_cnt;
  logic                  w_load_pend;
  logic                  w_redirect;

  // --------------------------------------------------------------------------
  // State, pending target and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_pend_target  <= '0;
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_pend) begin
        r_pend_target <= branch_target;
      end
      if (stall[0] && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_redirect && (r_redirect_cnt != {CNT_WIDTH{1'b1}})) begin
        r_redirect_cnt <= r_redirect_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall vector, next state and redirect outputs (zero-latency)
  // --------------------------------------------------------------------------
  always_comb begin
    stall        = '0;
    flush        = 1'b0;
    new_pc_valid = 1'b0;
    new_pc       = '0;
    w_state_nxt  = r_state;
    w_load_pend  = 1'b0;
    w_redirect   = 1'b0;

    if (rst) begin
      if (stallreq_mem) begin
        stall = c_STALL_MEM;
      end else if (stallreq_id) begin
        stall = c_STALL_ID;
      end else if (stallreq_if) begin
        stall = c_STALL_IF;
      end

      case (r_state)
        ST_RUN: begin
          // While MEM stalls, EX is frozen and will present the branch again.
          if (branch_flag && !stallreq_mem) begin
            flush = 1'b1;
            if (!stallreq_if) begin
              new_pc_valid = 1'b1;
              new_pc       = branch_target;
              w_redirect   = 1'b1;
            end else begin
              // The fetch in flight is on the wrong path. Keep the target
              // until that fetch has completed.
              w_load_pend = 1'b1;
              w_state_nxt = ST_PEND_BR;
            end
          end
        end
        ST_PEND_BR: begin
          // Keep flushing so the wrong-path fetch never reaches ID. EX holds
          // only bubbles here, so branch_flag has no meaning.
          flush = 1'b1;
          if (!stallreq_if && !stallreq_mem) begin
            new_pc_valid = 1'b1;
            new_pc       = r_pend_target;
            w_redirect   = 1'b1;
            w_state_nxt  = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed testbench for pipeline_ctrl. Each check compares
//               against an expected value worked out by hand. A second
//               instance with narrow counters is used to exercise counter
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_mem;
  logic        branch_flag;
  logic [31:0] branch_target;

  logic [5:0]  stall;
  logic        flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic [31:0] redirect_cnt;

  logic [5:0]  s_stall;
  logic        s_flush;
  logic        s_new_pc_valid;
  logic [31:0] s_new_pc;
  logic [2:0]  s_stall_cnt;
  logic [2:0]  s_redirect_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(
    .CTRL_WIDTH(6),
    .ADDR_WIDTH(32),
    .CNT_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_mem (stallreq_mem),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .stall        (stall),
    .flush        (flush),
    .new_pc_valid (new_pc_valid),
    .new_pc       (new_pc),
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt)
  );

  pipeline_ctrl #(
    .CTRL_WIDTH(6),
    .ADDR_WIDTH(32),
    .CNT_WIDTH (3)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_mem (stallreq_mem),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .stall        (s_stall),
    .flush        (s_flush),
    .new_pc_valid (s_new_pc_valid),
    .new_pc       (s_new_pc),
    .stall_cnt    (s_stall_cnt),
    .redirect_cnt (s_redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i_if, input logic i_id, input logic i_mem,
                       input logic br, input logic [31:0] tgt);
    stallreq_if   = i_if;
    stallreq_id   = i_id;
    stallreq_mem  = i_mem;
    branch_flag   = br;
    branch_target = tgt;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0);

    // Reset: outputs held low even with requests active.
    #2;
    drive(1, 0, 1, 1, 32'h0000_0abc);
    #1;
    check("rst_stall", stall, 6'b000000);
    check("rst_flush", flush, 1'b0);
    check("rst_npv", new_pc_valid, 1'b0);
    check("rst_newpc", new_pc, 32'h0);
    check("rst_scnt", stall_cnt, 32'd0);
    check("rst_rcnt", redirect_cnt, 32'd0);
    cyc();
    drive(0, 0, 0, 0, 32'h0);
    rst = 1'b1;

    // Stall priority: MEM > ID > IF.
    drive(1, 1, 1, 0, 32'h0);
    #1; check("prio_mem", stall, 6'b011111);
    cyc();
    drive(1, 1, 0, 0, 32'h0);
    #1; check("prio_id", stall, 6'b000111);
    cyc();
    drive(1, 0, 0, 0, 32'h0);
    #1; check("prio_if", stall, 6'b000011);
    cyc();
    drive(0, 0, 0, 0, 32'h0);
    #1; check("prio_none", stall, 6'b000000);
    check("scnt_3", stall_cnt, 32'd3);

    // Immediate redirect.
    drive(0, 0, 0, 1, 32'h0000_1040);
    #1;
    check("imm_flush", flush, 1'b1);
    check("imm_npv", new_pc_valid, 1'b1);
    check("imm_newpc", new_pc, 32'h0000_1040);
    cyc();
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("imm_rcnt", redirect_cnt, 32'd1);
    check("imm_after_npv", new_pc_valid, 1'b0);
    check("imm_after_newpc", new_pc, 32'h0);

    // Deferred redirect behind an outstanding fetch.
    drive(1, 0, 0, 1, 32'h0000_2000);
    #1;
    check("def1_flush", flush, 1'b1);
    check("def1_npv", new_pc_valid, 1'b0);
    check("def1_stall", stall, 6'b000011);
    cyc();
    drive(1, 0, 0, 1, 32'h0000_3000);
    #1;
    check("def2_flush", flush, 1'b1);
    check("def2_npv", new_pc_valid, 1'b0);
    cyc();
    drive(1, 0, 0, 0, 32'h0);
    #1;
    check("def3_flush", flush, 1'b1);
    check("def3_npv", new_pc_valid, 1'b0);
    cyc();
    drive(0, 0, 0, 1, 32'h0000_3000);
    #1;
    check("def4_flush", flush, 1'b1);
    check("def4_npv", new_pc_valid, 1'b1);
    check("def4_newpc", new_pc, 32'h0000_2000);
    cyc();
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("def_rcnt", redirect_cnt, 32'd2);
    check("def_scnt", stall_cnt, 32'd6);
    check("def_back_run_flush", flush, 1'b0);

    // MEM stall blocks branch acceptance.
    drive(0, 0, 1, 1, 32'h0000_4000);
    #1;
    check("mem1_flush", flush, 1'b0);
    check("mem1_stall", stall, 6'b011111);
    cyc();
    #1;
    check("mem2_flush", flush, 1'b0);
    check("mem2_npv", new_pc_valid, 1'b0);
    cyc();
    drive(0, 0, 0, 1, 32'h0000_4000);
    #1;
    check("mem3_flush", flush, 1'b1);
    check("mem3_npv", new_pc_valid, 1'b1);
    check("mem3_newpc", new_pc, 32'h0000_4000);
    cyc();
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("mem_rcnt", redirect_cnt, 32'd3);
    check("mem_scnt", stall_cnt, 32'd8);

    // Pending redirect held back by a MEM stall.
    drive(1, 0, 0, 1, 32'h0000_5000);
    cyc();
    drive(0, 0, 1, 0, 32'h0);
    #1;
    check("pmem_npv", new_pc_valid, 1'b0);
    check("pmem_stall", stall, 6'b011111);
    cyc();
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("pmem_rel_npv", new_pc_valid, 1'b1);
    check("pmem_rel_newpc", new_pc, 32'h0000_5000);
    cyc();
    check("pmem_rcnt", redirect_cnt, 32'd4);
    check("pmem_scnt", stall_cnt, 32'd10);

    // Asynchronous reset in the middle of PEND_BR.
    drive(1, 0, 0, 1, 32'h0000_6000);
    cyc();
    drive(1, 0, 0, 0, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_stall", stall, 6'b000000);
    check("arst_flush", flush, 1'b0);
    check("arst_npv", new_pc_valid, 1'b0);
    check("arst_scnt", stall_cnt, 32'd0);
    check("arst_rcnt", redirect_cnt, 32'd0);
    cyc();
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    #1;
    check("arst_dropped_npv", new_pc_valid, 1'b0);
    check("arst_dropped_flush", flush, 1'b0);

    // Saturation on the 3-bit counter instance.
    drive(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 7; i++) cyc();
    check("sat_scnt_7", s_stall_cnt, 3'd7);
    for (int i = 0; i < 3; i++) cyc();
    check("sat_scnt_hold", s_stall_cnt, 3'd7);
    drive(0, 0, 0, 1, 32'h0000_0100);
    for (int i = 0; i < 9; i++) cyc();
    check("sat_rcnt_hold", s_redirect_cnt, 3'd7);
    check("sat_main_scnt", stall_cnt, 32'd10);
    drive(0, 0, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
